uart_telemetry_scheduler: RTL and testbench

- Periodically snapshots the measured rpm of all four motor channels and the per-channel stop flags.
- Sequences the snapshot as a fixed 11-byte frame onto a single shared UART transmitter byte interface.
- Frame is the transmit-side counterpart of the set_rpm command format: same {chn, rpm_hi5} / rpm_lo8 byte pairs, same 0xFF terminator.
- Sits between the PID/encoder channels and the UART send module.

---
 rtl/uart_telemetry_scheduler_pkg.sv | 39 +++
 rtl/telemetry_period_timer.sv | 35 +++
 rtl/uart_telemetry_scheduler.sv | 120 ++++++++++++
 tb/tb_uart_telemetry_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_telemetry_scheduler_pkg.sv
// Shared constants and types for the UART command decoder and telemetry scheduler.
package uart_telemetry_scheduler_pkg;

  localparam logic [7:0]  CMD_HDR_BYTE   = 8'h91;
  localparam logic [7:0]  TLM_HDR_BYTE   = 8'h92;
  localparam logic [7:0]  FRAME_END_BYTE = 8'hFF;
  localparam int unsigned CHN_WIDTH      = 3;
  localparam int unsigned SAT_WIDTH      = 13;
  localparam int unsigned TLM_NUM_CHN    = 4;
  localparam int          RPM_SAT_MAX    = 4095;
  localparam int          RPM_SAT_MIN    = -4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HI,
    ST_LO,
    ST_STAT,
    ST_END
  } tlm_state_e;

  typedef logic [SAT_WIDTH-1:0] rpm_sat_t;

  typedef struct packed {
    rpm_sat_t [TLM_NUM_CHN-1:0] rpm;
    logic     [TLM_NUM_CHN-1:0] stop;
  } tlm_snapshot_t;

  // Clamp a sign-extended rpm value into the 13-bit signed range carried by HI/LO bytes.
  function automatic rpm_sat_t sat_rpm(input logic signed [31:0] value);
    if (value > RPM_SAT_MAX) begin
      return SAT_WIDTH'(RPM_SAT_MAX);
    end else if (value < RPM_SAT_MIN) begin
      return SAT_WIDTH'(RPM_SAT_MIN);
    end
    return value[SAT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/telemetry_period_timer.sv
// Free-running frame period timer; tick_o is high for one cycle while the count sits at PERIOD_CYCLES-1.
module telemetry_period_timer #(
  parameter int unsigned PERIOD_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned          CNT_WIDTH = $clog2(PERIOD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(PERIOD_CYCLES - 1);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = '0;
    if (enable_i && (count_q != CNT_LAST)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  // Tick is registered from count_d so it coincides with count_q == CNT_LAST.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      tick_o  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_o  <= (count_d == CNT_LAST);
    end
  end

endmodule

// File: rtl/uart_telemetry_scheduler.sv
// Snapshots four channel rpms plus stop flags each period and streams an 11-byte frame to the UART sender.
module uart_telemetry_scheduler
  import uart_telemetry_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned NUM_CHN       = 4,
  parameter int unsigned PERIOD_CYCLES = 5000000
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         enable_i,
  input  logic signed [DATA_WIDTH-1:0] rpm_ch0_i,
  input  logic signed [DATA_WIDTH-1:0] rpm_ch1_i,
  input  logic signed [DATA_WIDTH-1:0] rpm_ch2_i,
  input  logic signed [DATA_WIDTH-1:0] rpm_ch3_i,
  input  logic [3:0]                   stop_i,
  input  logic                         tx_ready_i,
  output logic                         tx_valid_o,
  output logic [7:0]                   tx_data_o,
  output logic                         busy_o,
  output logic                         overrun_o
);

  localparam logic [CHN_WIDTH-1:0] CH_LAST = CHN_WIDTH'(NUM_CHN - 1);

  tlm_state_e           state_q, state_d;
  logic [CHN_WIDTH-1:0] ch_q, ch_d;
  tlm_snapshot_t        snap_q, snap_d;
  logic                 tx_valid_d;
  logic [7:0]           tx_data_d;
  logic                 busy_d;
  logic                 overrun_d;
  logic                 period_tick;
  logic                 xfer_c;

  telemetry_period_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .enable_i(enable_i),
    .tick_o  (period_tick)
  );

  assign xfer_c = tx_valid_o && tx_ready_i;

  // Next state plus the byte for that state, so outputs are registered alongside state_q.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    snap_d    = snap_q;
    tx_data_d = '0;
    overrun_d = period_tick && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (period_tick) begin
          snap_d.rpm[0] = sat_rpm(32'(rpm_ch0_i));
          snap_d.rpm[1] = sat_rpm(32'(rpm_ch1_i));
          snap_d.rpm[2] = sat_rpm(32'(rpm_ch2_i));
          snap_d.rpm[3] = sat_rpm(32'(rpm_ch3_i));
          snap_d.stop   = stop_i;
          ch_d          = '0;
          state_d       = ST_HDR;
        end
      end
      ST_HDR: if (xfer_c) begin
        ch_d    = '0;
        state_d = ST_HI;
      end
      ST_HI:  if (xfer_c) state_d = ST_LO;
      ST_LO: begin
        if (xfer_c) begin
          if (ch_q == CH_LAST) begin
            state_d = ST_STAT;
          end else begin
            ch_d    = ch_q + CHN_WIDTH'(1);
            state_d = ST_HI;
          end
        end
      end
      ST_STAT: if (xfer_c) state_d = ST_END;
      ST_END:  if (xfer_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_HDR:  tx_data_d = TLM_HDR_BYTE;
      ST_HI:   tx_data_d = {ch_d, snap_d.rpm[ch_d[1:0]][12:8]};
      ST_LO:   tx_data_d = snap_d.rpm[ch_d[1:0]][7:0];
      ST_STAT: tx_data_d = {4'b0000, snap_d.stop};
      ST_END:  tx_data_d = FRAME_END_BYTE;
      default: tx_data_d = '0;
    endcase

    tx_valid_d = (state_d != ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      snap_q     <= '0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      busy_o     <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      snap_q     <= snap_d;
      tx_valid_o <= tx_valid_d;
      tx_data_o  <= tx_data_d;
      busy_o     <= busy_d;
      overrun_o  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_telemetry_scheduler.sv
// Directed bench: frame contents, saturation, stalls, overrun, enable and mid-frame reset.
module tb_uart_telemetry_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstn;
  logic               enable_i, en10;
  logic signed [15:0] rpm0, rpm1, rpm2, rpm3;
  logic [3:0]         stop;
  logic               tx_ready_i, rdy10;
  logic               tx_valid_o, busy_o, overrun_o;
  logic [7:0]         tx_data_o;
  logic               v10, busy10, ov10;
  logic [7:0]         d10;

  int checks = 0;
  int errors = 0;

  logic [7:0] cap [11];
  logic [7:0] exp_b [11];
  int         cap_n, cap_wait, cap_unstable;
  bit         cap_timeout, cap_busy0;

  uart_telemetry_scheduler #(.DATA_WIDTH(16), .NUM_CHN(4), .PERIOD_CYCLES(100)) dut (
    .clk(clk), .rstn(rstn), .enable_i(enable_i),
    .rpm_ch0_i(rpm0), .rpm_ch1_i(rpm1), .rpm_ch2_i(rpm2), .rpm_ch3_i(rpm3),
    .stop_i(stop), .tx_ready_i(tx_ready_i),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  uart_telemetry_scheduler #(.DATA_WIDTH(16), .NUM_CHN(4), .PERIOD_CYCLES(10)) dut10 (
    .clk(clk), .rstn(rstn), .enable_i(en10),
    .rpm_ch0_i(rpm0), .rpm_ch1_i(rpm1), .rpm_ch2_i(rpm2), .rpm_ch3_i(rpm3),
    .stop_i(stop), .tx_ready_i(rdy10),
    .tx_valid_o(v10), .tx_data_o(d10), .busy_o(busy10), .overrun_o(ov10)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for the frame start, then records n transfers; called at a negedge.
  task automatic capture(input int n, input bit throttle, input int mutate_at, input int drop_at);
    int         cyc;
    bit         pend;
    logic [7:0] held;
    for (int i = 0; i < 11; i++) cap[i] = 8'h00;
    cap_n = 0; cap_wait = 0; cap_unstable = 0; cap_timeout = 0; cap_busy0 = 0;
    pend = 0; held = 8'h00; cyc = 0;
    while (!tx_valid_o && cap_wait < 400) begin
      @(posedge clk); @(negedge clk);
      cap_wait++;
    end
    if (!tx_valid_o) begin
      cap_timeout = 1;
      return;
    end
    cap_busy0 = busy_o;
    while (cap_n < n && cyc < 300) begin
      tx_ready_i = throttle ? (cyc % 3 == 2) : 1'b1;
      if (cyc == mutate_at) begin
        rpm0 = -16'sd1; rpm1 = 16'sd1234; rpm2 = -16'sd5000; rpm3 = 16'sd7;
        stop = ~stop;
      end
      if (pend && (!tx_valid_o || tx_data_o !== held)) cap_unstable++;
      pend = tx_valid_o && !tx_ready_i;
      held = tx_data_o;
      if (tx_valid_o && tx_ready_i) begin
        cap[cap_n] = tx_data_o;
        cap_n++;
        if (cap_n == drop_at) enable_i = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    if (cap_n < n) cap_timeout = 1;
    tx_ready_i = 1'b1;
  endtask

  // Re-arms the P=100 timer so the next frame starts on the 101st cycle.
  task automatic restart();
    @(negedge clk);
    enable_i = 1'b0;
    @(posedge clk); @(negedge clk);
    enable_i = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable_i = 1'b0; en10 = 1'b0; tx_ready_i = 1'b1; rdy10 = 1'b1;
    rpm0 = 0; rpm1 = 0; rpm2 = 0; rpm3 = 0; stop = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_valid_o !== 1'b0 || busy_o !== 1'b0 || overrun_o !== 1'b0 || tx_data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b busy=%b ovr=%b data=%h required 0/0/0/00",
               tx_valid_o, busy_o, overrun_o, tx_data_o);
    end
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_disabled: valid=%b busy=%b required 0/0", tx_valid_o, busy_o);
    end
  endtask

  task automatic test_basic_frame();
    rpm0 = 16'sd300; rpm1 = -16'sd300; rpm2 = 16'sd0; rpm3 = 16'sd4095; stop = 4'b0100;
    exp_b = '{8'h92, 8'h01, 8'h2C, 8'h3E, 8'hD4, 8'h40, 8'h00, 8'h6F, 8'hFF, 8'h04, 8'hFF};
    restart();
    capture(11, 1'b0, -1, -1);
    checks++;
    if (cap_timeout || cap_wait != 100 || !cap_busy0) begin
      errors++;
      $display("FAIL basic_start: timeout=%b wait=%0d busy=%b required 0/100/1", cap_timeout, cap_wait, cap_busy0);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (cap[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL basic_byte%0d: got %h required %h", i, cap[i], exp_b[i]);
      end
    end
    checks++;
    if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: valid=%b busy=%b required 0/0", tx_valid_o, busy_o);
    end
  endtask

  task automatic test_saturation();
    rpm0 = 16'sd20000; rpm1 = -16'sd20000; rpm2 = -16'sd4096; rpm3 = 16'sd4096; stop = 4'b1010;
    exp_b = '{8'h92, 8'h0F, 8'hFF, 8'h30, 8'h00, 8'h50, 8'h00, 8'h6F, 8'hFF, 8'h0A, 8'hFF};
    restart();
    capture(11, 1'b0, -1, -1);
    checks++;
    if (cap_timeout) begin
      errors++;
      $display("FAIL sat_timeout: captured %0d bytes required 11", cap_n);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (cap[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL sat_byte%0d: got %h required %h", i, cap[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_stall_coherency();
    rpm0 = 16'sd300; rpm1 = -16'sd300; rpm2 = 16'sd0; rpm3 = 16'sd4095; stop = 4'b0100;
    exp_b = '{8'h92, 8'h01, 8'h2C, 8'h3E, 8'hD4, 8'h40, 8'h00, 8'h6F, 8'hFF, 8'h04, 8'hFF};
    restart();
    capture(11, 1'b1, 4, -1);
    checks++;
    if (cap_timeout || cap_unstable != 0) begin
      errors++;
      $display("FAIL stall_handshake: timeout=%b unstable=%0d required 0/0", cap_timeout, cap_unstable);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (cap[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL stall_byte%0d: got %h required %h", i, cap[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_overrun();
    int w, ovc, n, drops;
    logic [7:0] first_b, last_b;
    rpm0 = 16'sd300; rpm1 = -16'sd300; rpm2 = 16'sd0; rpm3 = 16'sd4095; stop = 4'b0100;
    @(negedge clk);
    rdy10 = 1'b0;
    en10  = 1'b1;
    w = 0;
    while (!v10 && w < 50) begin
      @(posedge clk); @(negedge clk);
      w++;
    end
    checks++;
    if (w != 10) begin
      errors++;
      $display("FAIL ovr_start: wait=%0d required 10", w);
    end
    ovc = 0; drops = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); @(negedge clk);
      if (ov10) ovc++;
      if (!v10) drops++;
    end
    checks++;
    if (ovc != 3 || drops != 0) begin
      errors++;
      $display("FAIL ovr_pulses: pulses=%0d valid_drops=%0d required 3/0", ovc, drops);
    end
    rdy10 = 1'b1;
    n = 0; first_b = 8'h00; last_b = 8'h00;
    for (int i = 0; i < 20 && n < 11; i++) begin
      if (v10) begin
        if (n == 0) first_b = d10;
        last_b = d10;
        n++;
      end
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (n != 11 || first_b !== 8'h92 || last_b !== 8'hFF) begin
      errors++;
      $display("FAIL ovr_frame: bytes=%0d first=%h last=%h required 11/92/ff", n, first_b, last_b);
    end
    checks++;
    if (v10 !== 1'b0 || busy10 !== 1'b0) begin
      errors++;
      $display("FAIL ovr_no_back_to_back: valid=%b busy=%b required 0/0", v10, busy10);
    end
    en10 = 1'b0;
  endtask

  task automatic test_enable_drop();
    int seen;
    rpm0 = 16'sd300; rpm1 = -16'sd300; rpm2 = 16'sd0; rpm3 = 16'sd4095; stop = 4'b0100;
    restart();
    capture(11, 1'b0, -1, 5);
    checks++;
    if (cap_timeout || cap[0] !== 8'h92 || cap[10] !== 8'hFF || cap[9] !== 8'h04) begin
      errors++;
      $display("FAIL drop_frame: timeout=%b first=%h stat=%h last=%h required 0/92/04/ff",
               cap_timeout, cap[0], cap[9], cap[10]);
    end
    seen = 0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk); @(negedge clk);
      if (tx_valid_o || busy_o) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL drop_idle: active_cycles=%0d required 0", seen);
    end
    enable_i = 1'b1;
    capture(11, 1'b0, -1, -1);
    checks++;
    if (cap_timeout || cap_wait != 100 || cap[0] !== 8'h92) begin
      errors++;
      $display("FAIL reenable_latency: timeout=%b wait=%0d hdr=%h required 0/100/92", cap_timeout, cap_wait, cap[0]);
    end
  endtask

  task automatic test_reset_midframe();
    rpm0 = 16'sd300; rpm1 = -16'sd300; rpm2 = 16'sd0; rpm3 = 16'sd4095; stop = 4'b0100;
    restart();
    capture(7, 1'b0, -1, -1);
    checks++;
    if (cap_timeout || tx_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL midframe_active: timeout=%b valid=%b busy=%b required 0/1/1", cap_timeout, tx_valid_o, busy_o);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (tx_valid_o !== 1'b0 || busy_o !== 1'b0 || tx_data_o !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: valid=%b busy=%b data=%h required 0/0/00", tx_valid_o, busy_o, tx_data_o);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    capture(11, 1'b0, -1, -1);
    checks++;
    if (cap_timeout || cap_wait != 100 || cap[0] !== 8'h92 || cap[10] !== 8'hFF) begin
      errors++;
      $display("FAIL post_reset_frame: timeout=%b wait=%0d first=%h last=%h required 0/100/92/ff",
               cap_timeout, cap_wait, cap[0], cap[10]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_saturation();
    test_stall_coherency();
    test_overrun();
    test_enable_drop();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
